uart_baud_gen_frac: RTL and testbench

- Parametrised fractional baud generator, successor to the fixed-table UART baud generator.
- Produces an oversample tick at OVERSAMPLE× the baud rate using an integer-plus-fraction divisor, so the average bit period is exact to 1/2^FRAC_W clock.
- Also produces a mid-bit sample strobe for the RX path and a bit-boundary strobe for the TX path.
- Divisor comes from an elaboration-time rate table or from a runtime custom divisor.

---
 rtl/uart_baud_gen_frac_if.sv | 30 +++
 rtl/uart_baud_gen_frac.sv | 133 +++++++++++++
 tb/tb_uart_baud_gen_frac.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/uart_baud_gen_frac_if.sv
// Control and strobe bundle between a UART baud generator and its user.
// The user drives the configuration and enable; the generator returns the timing strobes.
interface uart_baud_gen_frac_if #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);

    logic              en;
    logic [3:0]        baud_sel;
    logic [DIV_W-1:0]  div_int;
    logic [FRAC_W-1:0] div_frac;
    logic              load;
    logic              os_tick;
    logic [OS_W-1:0]   os_cnt;
    logic              mid_strobe;
    logic              bit_strobe;
    logic              cfg_err;

    modport master (
        output en, baud_sel, div_int, div_frac, load,
        input  os_tick, os_cnt, mid_strobe, bit_strobe, cfg_err
    );

    modport slave (
        input  en, baud_sel, div_int, div_frac, load,
        output os_tick, os_cnt, mid_strobe, bit_strobe, cfg_err
    );
endinterface

// File: rtl/uart_baud_gen_frac.sv
// Fractional UART baud generator: oversample tick from an int+frac divisor,
// plus mid-bit (RX sample) and bit-boundary (TX) strobes.
module uart_baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input logic                  clk,
    input logic                  rst,
    uart_baud_gen_frac_if.slave  bus
);
    localparam int unsigned OS_W = $clog2(OVERSAMPLE);
    localparam int unsigned DW   = DIV_W + FRAC_W;

    typedef logic [DW-1:0] div_t;

    // Rounded fixed-point divisor: CLK_FREQ * 2^FRAC_W / (baud * OVERSAMPLE)
    function automatic div_t calc_div(input int unsigned baud);
        longint unsigned num;
        longint unsigned den;
        num = 64'(CLK_FREQ) << FRAC_W;
        den = 64'(baud) * 64'(OVERSAMPLE);
        return DW'((64'd2 * num + den) / (64'd2 * den));
    endfunction

    localparam div_t DIV_9600 = calc_div(9600);

    // Entries 10..15 fall back to 9600; 15 is overridden by the custom ports.
    localparam div_t DIV_TAB [16] = '{
        calc_div(1200),  calc_div(2400),  calc_div(4800),  DIV_9600,
        calc_div(14400), calc_div(19200), calc_div(28800), calc_div(38400),
        calc_div(57600), calc_div(115200),
        DIV_9600, DIV_9600, DIV_9600, DIV_9600, DIV_9600, DIV_9600
    };

    localparam logic [DIV_W-1:0]  RST_INT  = DIV_W'(DIV_9600 >> FRAC_W);
    localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(DIV_9600);
    localparam logic [OS_W-1:0]   OS_MID_M1 = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);

    logic [DIV_W-1:0]  sh_int;
    logic [FRAC_W-1:0] sh_frac;
    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] frac_acc;
    logic              carry;
    logic [OS_W-1:0]   os_cnt_q;
    logic              os_tick_q;
    logic              mid_q;
    logic              bit_q;
    logic              err_q;

    div_t              ld_div;
    logic [DIV_W-1:0]  ld_int;
    logic [FRAC_W-1:0] ld_frac;
    logic              ld_err;
    logic [DIV_W:0]    last_cnt;
    logic              period_end;
    logic [FRAC_W:0]   frac_sum;

    // Configuration decode for the next load, with the minimum-divisor clamp.
    always_comb begin
        ld_div  = DIV_TAB[bus.baud_sel];
        ld_int  = DIV_W'(ld_div >> FRAC_W);
        ld_frac = ld_div[FRAC_W-1:0];
        ld_err  = (bus.baud_sel >= 4'd10) && (bus.baud_sel <= 4'd14);
        if (bus.baud_sel == 4'd15) begin
            ld_int  = bus.div_int;
            ld_frac = bus.div_frac;
        end
        if (ld_int < DIV_W'(2)) begin
            ld_int = DIV_W'(2);
        end
    end

    // Current period is int+carry long; counter runs 0..N-1.
    always_comb begin
        last_cnt   = (DIV_W+1)'(sh_int) + (DIV_W+1)'(carry) - (DIV_W+1)'(1);
        period_end = ({1'b0, cnt} == last_cnt);
        frac_sum   = {1'b0, frac_acc} + {1'b0, sh_frac};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_int    <= RST_INT;
            sh_frac   <= RST_FRAC;
            err_q     <= 1'b0;
            cnt       <= '0;
            frac_acc  <= '0;
            carry     <= 1'b0;
            os_cnt_q  <= '0;
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
        end else if (bus.load) begin
            sh_int    <= ld_int;
            sh_frac   <= ld_frac;
            err_q     <= ld_err;
            cnt       <= '0;
            frac_acc  <= '0;
            carry     <= 1'b0;
            os_cnt_q  <= '0;
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
        end else if (bus.en) begin
            if (period_end) begin
                cnt       <= '0;
                {carry, frac_acc} <= frac_sum;
                os_cnt_q  <= os_cnt_q + OS_W'(1);
                os_tick_q <= 1'b1;
                mid_q     <= (os_cnt_q == OS_MID_M1);
                bit_q     <= (os_cnt_q == OS_LAST);
            end else begin
                cnt       <= cnt + DIV_W'(1);
                os_tick_q <= 1'b0;
                mid_q     <= 1'b0;
                bit_q     <= 1'b0;
            end
        end else begin
            os_tick_q <= 1'b0;
            mid_q     <= 1'b0;
            bit_q     <= 1'b0;
        end
    end

    assign bus.os_tick    = os_tick_q;
    assign bus.os_cnt     = os_cnt_q;
    assign bus.mid_strobe = mid_q;
    assign bus.bit_strobe = bit_q;
    assign bus.cfg_err    = err_q;

endmodule

// File: tb/tb_uart_baud_gen_frac.sv
// Randomized and directed check of uart_baud_gen_frac against a closed-form
// tick-time model: tick n lands n*int + floor((n-1)*frac/2^FRAC_W) enabled edges after restart.
module tb_uart_baud_gen_frac;
    localparam int unsigned CLK_FREQ = 100_000_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DIV_W    = 16;
    localparam int unsigned FRAC_W   = 4;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    uart_baud_gen_frac_if #(.OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)) bus ();

    uart_baud_gen_frac #(
        .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int total = 0;
    int bad   = 0;

    int rates [10] = '{1200, 2400, 4800, 9600, 14400, 19200, 28800, 38400, 57600, 115200};

    // model state
    longint m_int, m_frac, e, k;
    logic   m_err;
    logic   exp_tick, exp_mid, exp_bit;

    // observed-timing measurements
    int cyc, first_tick, last_tick, tick_gap, last_bit, bit_gap;
    int n_long, long_per_bit, ticks_since_bit, mid_pos;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic longint tb_div(input int baud);
        real d;
        d = real'(CLK_FREQ) * (2.0 ** FRAC_W) / (real'(baud) * real'(OS));
        return longint'($rtoi(d + 0.5));
    endfunction

    function automatic longint t_of(input longint n);
        return n * m_int + (((n - 1) * m_frac) >> FRAC_W);
    endfunction

    task automatic set_div(input longint d);
        m_int  = d >> FRAC_W;
        m_frac = d % (64'd1 << FRAC_W);
    endtask

    task automatic restart();
        e = 0; k = 0;
        exp_tick = 1'b0; exp_mid = 1'b0; exp_bit = 1'b0;
        cyc = 0; first_tick = -1; last_tick = 0; tick_gap = 0;
        last_bit = 0; bit_gap = 0; n_long = 0; long_per_bit = -1;
        ticks_since_bit = 0; mid_pos = -1;
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        if (!rst) begin
            set_div(tb_div(9600));
            m_err = 1'b0;
            restart();
        end else if (bus.load) begin
            if (bus.baud_sel == 4'd15) begin
                m_int  = (bus.div_int < 2) ? 64'd2 : 64'(bus.div_int);
                m_frac = 64'(bus.div_frac);
                m_err  = 1'b0;
            end else if (bus.baud_sel >= 4'd10) begin
                set_div(tb_div(9600));
                m_err = 1'b1;
            end else begin
                set_div(tb_div(rates[bus.baud_sel]));
                m_err = 1'b0;
            end
            restart();
        end else if (bus.en) begin
            e++;
            if (e == t_of(k + 1)) begin
                k++;
                exp_tick = 1'b1;
                exp_mid  = (k % OS) == OS / 2;
                exp_bit  = (k % OS) == 0;
            end else begin
                exp_tick = 1'b0; exp_mid = 1'b0; exp_bit = 1'b0;
            end
        end else begin
            exp_tick = 1'b0; exp_mid = 1'b0; exp_bit = 1'b0;
        end
        #1;
        check("os_tick",    32'(bus.os_tick),    32'(exp_tick));
        check("os_cnt",     32'(bus.os_cnt),     32'(k % OS));
        check("mid_strobe", 32'(bus.mid_strobe), 32'(exp_mid));
        check("bit_strobe", 32'(bus.bit_strobe), 32'(exp_bit));
        check("cfg_err",    32'(bus.cfg_err),    32'(m_err));
        if (bus.os_tick === 1'b1) begin
            if (first_tick < 0) first_tick = cyc;
            tick_gap  = cyc - last_tick;
            last_tick = cyc;
            if (tick_gap == int'(m_int) + 1) n_long++;
            ticks_since_bit++;
        end
        if (bus.mid_strobe === 1'b1) mid_pos = ticks_since_bit;
        if (bus.bit_strobe === 1'b1) begin
            bit_gap  = cyc - last_bit;
            last_bit = cyc;
            long_per_bit = n_long;
            n_long = 0;
            ticks_since_bit = 0;
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_load(input logic [3:0] sel, input logic [DIV_W-1:0] di, input logic [FRAC_W-1:0] df);
        bus.baud_sel = sel; bus.div_int = di; bus.div_frac = df; bus.load = 1'b1;
        step();
        bus.load = 1'b0;
    endtask

    // advance until the period counter (edges since last tick) reaches target
    task automatic run_to_phase(input string tag, input longint target);
        int n;
        n = 0;
        while ((e - t_of(k)) != target && n < 20000) begin
            step();
            n++;
        end
        check(tag, 32'(n < 20000), 32'd1);
    endtask

    initial begin
        int n, gap_ticks;
        rst = 1'b0;
        bus.en = 1'b0; bus.load = 1'b0; bus.baud_sel = 4'd0;
        bus.div_int = '0; bus.div_frac = '0;
        m_int = 0; m_frac = 0; m_err = 1'b0;
        restart();
        run(3);
        rst = 1'b1;

        // 9600: first tick, bit period, one long interval per bit
        bus.en = 1'b1;
        do_load(4'd3, '0, '0);
        run(700);
        check("first_tick_9600", 32'(first_tick), 32'd651);
        run(21000);
        check("bit_gap_9600", 32'(bit_gap), 32'd10417);
        check("long_per_bit_9600", 32'(long_per_bit), 32'd1);

        // enable gap at counter=300
        run_to_phase("wait_cnt300", 300);
        bus.en = 1'b0;
        gap_ticks = 0;
        for (int i = 0; i < 100; i++) begin
            step();
            if (bus.os_tick || bus.mid_strobe || bus.bit_strobe) gap_ticks++;
        end
        check("gap_strobes", 32'(gap_ticks), 32'd0);
        bus.en = 1'b1;
        n = 0;
        do begin
            step();
            n++;
        end while (bus.os_tick !== 1'b1 && n < 1000);
        check("resume_latency", 32'(n), 32'd351);

        // 115200: 54/54/54/55 pattern, 868-cycle bits, mid 8 ticks after bit
        do_load(4'd9, '0, '0);
        run(2000);
        check("bit_gap_115200", 32'(bit_gap), 32'd868);
        check("mid_after_bit", 32'(mid_pos), 32'd8);
        check("long_per_bit_115200", 32'(long_per_bit), 32'd4);

        // clamped custom divisor
        do_load(4'd15, 16'd1, 4'd0);
        run(40);
        check("clamp_gap", 32'(tick_gap), 32'd2);
        check("clamp_cfg_err", 32'(bus.cfg_err), 32'd0);

        // reserved select, then 1200
        do_load(4'd12, '0, '0);
        check("cfg_err_reserved", 32'(bus.cfg_err), 32'd1);
        run(700);
        check("first_tick_reserved", 32'(first_tick), 32'd651);
        do_load(4'd0, '0, '0);
        check("cfg_err_cleared", 32'(bus.cfg_err), 32'd0);
        run(5300);
        check("first_tick_1200", 32'(first_tick), 32'd5208);

        // reset mid-period at counter=400
        do_load(4'd9, '0, '0);
        run(100);
        do_load(4'd3, '0, '0);
        run_to_phase("wait_cnt400", 400);
        rst = 1'b0;
        step();
        rst = 1'b1;
        check("rst_os_cnt", 32'(bus.os_cnt), 32'd0);
        run(700);
        check("first_tick_after_rst", 32'(first_tick), 32'd651);

        // randomized configurations, enable dropouts and unloaded input churn
        for (int it = 0; it < 20; it++) begin
            case ($urandom_range(0, 3))
                0: do_load(4'd15, DIV_W'($urandom_range(0, 40)), FRAC_W'($urandom));
                1: do_load(4'd9, '0, '0);
                2: do_load(4'($urandom_range(10, 14)), '0, '0);
                default: do_load(4'd15, DIV_W'($urandom_range(2, 6)), FRAC_W'($urandom));
            endcase
            for (int c = 0; c < 400; c++) begin
                bus.en       = ($urandom_range(0, 9) != 0);
                bus.baud_sel = 4'($urandom);
                bus.div_int  = DIV_W'($urandom);
                bus.div_frac = FRAC_W'($urandom);
                rst          = ($urandom_range(0, 499) != 0);
                step();
                rst = 1'b1;
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
